pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Central stall/flush controller for the five-stage MIPS pipeline. Each cycle it produces the enable and flush strobes for the IF/ID, ID/EX, EX/MEM and MEM/WB latches and for the PC. It uses instruction/data cache hits, load-use and control hazards, and halt as inputs. It gives memory-stage data accesses priority over instruction fetch on the shared memory path, and keeps saturating cycle and stall counters for performance reporting.

## Interface
Parameters:
- CNT_W, 32, width of performance counters
- REG_W, 5, register-index width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  synchronous active-low reset, sampled on CLK rising edge
- ihit  in  1  instruction fetch completed this cycle
- dhit  in  1  data access completed this cycle
- dmemREN_mem, dmemWEN_mem  in  1 each  memory-stage instruction requests data read/write
- ex_MemRead  in  1  EX-stage instruction is a load
- ex_wsel  in  REG_W  EX-stage destination register
- id_rs, id_rt  in  REG_W each  ID-stage source registers
- branch_mem  in  1  branch resolved taken in MEM stage
- jump_id  in  1  jump decoded in ID stage
- halt_wb  in  1  halt instruction at MEM/WB output
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  load bubble (zeros) when the matching enable is high
- imemREN  out  1  instruction fetch request
- halted  out  1  sticky halt indication
- cycle_count, stall_count  out  CNT_W each  performance counters

## Operation
- States: RUN, DWAIT, HALT. Registered state. Reset state is RUN.
- All strobes are combinational from state and inputs. While nRST=0, every enable, flush and imemREN is forced to 0.
- dreq = dmemREN_mem | dmemWEN_mem.
- Load-use hazard: luh = ex_MemRead & (ex_wsel != 0) & (ex_wsel == id_rs | ex_wsel == id_rt).

RUN:
- imemREN = ~dreq.
- If dreq & ~dhit:
  - All enables = 0.
  - Next state DWAIT.
- If dreq & dhit:
  - Take the data-advance action, defined below. Stay in RUN.
- If ~dreq & ihit, advance, in priority order:
  1. branch_mem: all enables = 1; ifid_flush = idex_flush = exmem_flush = 1.
  2. luh: pc_en = ifid_en = 0; idex_en = exmem_en = memwb_en = 1; idex_flush = 1.
  3. jump_id: all enables = 1; ifid_flush = 1.
  4. Otherwise: all enables = 1, no flush.
- If ~dreq & ~ihit: all enables = 0.

DWAIT:
- imemREN = 0. ihit is ignored.
- On dhit: take the data-advance action; next state RUN.
- Otherwise: all enables = 0.

Data-advance action:
- memwb_en = exmem_en = idex_en = 1, with idex_flush = 1.
- ifid_en = pc_en = 0.
- The ID instruction is retained and refetch is not needed.
- branch_mem, luh and jump_id are not acted on; they are re-evaluated on the next advance.

Halt:
- halt_wb (any state, nRST=1) sends the next state to HALT. This takes priority over every other transition.
- HALT: all enables, flushes and imemREN = 0; halted = 1.
- HALT is left only by reset.
- halted is registered: it is 1 in the cycle after halt_wb is sampled.

Counters:
- cycle_count increments every cycle with state != HALT.
- stall_count increments every cycle with state != HALT and pc_en = 0.
- Both counters saturate at all-ones and do not wrap.
- Both counters reset to 0.

## Timing
- Reset values: state RUN, halted 0, cycle_count 0, stall_count 0.
- Zero-latency strobes: a hit in cycle N produces enables in cycle N, so the latches capture at the end of N.
- State transitions take effect at the next CLK edge.
- A RUN→DWAIT→RUN data access with dhit arriving k cycles after the request costs k+1 stall cycles: k cycles with pc_en = 0, plus the advance cycle.
- Simultaneous events:
  - dreq with ihit: data wins and ihit is dropped.
  - halt_wb with dhit: HALT wins next cycle, but the current-cycle strobes still follow the data-advance rule.
  - branch_mem with luh: branch wins.
- Reset asserted mid-DWAIT returns to RUN on the next edge and clears the counters.

## Test plan
- Reset, then ihit=1 continuously with no hazards:
  - All enables 1 and flushes 0 every cycle.
  - After 10 cycles, cycle_count=10 and stall_count=0.
- dmemREN_mem=1 with dhit delayed 3 cycles:
  - Enter DWAIT; enables 0 and imemREN=0 for 3 cycles.
  - In the dhit cycle: memwb_en/exmem_en/idex_en=1, idex_flush=1, pc_en=0.
  - Back in RUN; stall_count=4.
- ex_MemRead=1, ex_wsel=5, id_rt=5, ihit=1: pc_en=ifid_en=0 and idex_flush=1 for one cycle.
  - Repeat with ex_wsel=0: no stall.
- branch_mem=1 and luh=1 with ihit=1: all three flushes = 1 and pc_en=1.
- halt_wb=1: halted=1 next cycle with all strobes 0 thereafter.
  - Counters frozen; nRST=0 for one edge clears halted and the counters.
- Force stall_count to all-ones (CNT_W=4, 20 stalled cycles): counter holds at 15.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: stall/flush controller for the five-stage pipeline.
// Drives the PC and inter-stage latch enables/flushes. Data accesses in
// MEM own the shared memory path over instruction fetch. Also keeps
// saturating cycle and stall counters.
//
//  state | meaning
//  ------+---------------------------------------------------------
//  RUN   | normal issue; data access or fetch completes this cycle
//  DWAIT | memory-stage data access outstanding, pipeline frozen
//  HALT  | halt retired; everything frozen until reset
module pipeline_sequencer #(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmemREN_mem,
    input  logic             dmemWEN_mem,
    input  logic             ex_MemRead,
    input  logic [REG_W-1:0] ex_wsel,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             branch_mem,
    input  logic             jump_id,
    input  logic             halt_wb,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             imemREN,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             halted_q;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] stall_q;
    logic             dreq;
    logic             luh;
    logic             adv;

    assign dreq = dmemREN_mem | dmemWEN_mem;
    assign luh  = ex_MemRead & (ex_wsel != '0) &
                  ((ex_wsel == id_rs) | (ex_wsel == id_rt));

    // Zero-latency strobes and next state from current state and hits.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        imemREN     = 1'b0;
        adv         = 1'b0;
        state_d     = state_q;
        if (nRST) begin
            case (state_q)
                RUN: begin
                    imemREN = ~dreq;
                    if (dreq) begin
                        if (dhit) adv = 1'b1;
                        else      state_d = DWAIT;
                    end else if (ihit) begin
                        if (branch_mem) begin
                            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                            {ifid_flush, idex_flush, exmem_flush} = 3'b111;
                        end else if (luh) begin
                            {idex_en, exmem_en, memwb_en} = 3'b111;
                            idex_flush = 1'b1;
                        end else if (jump_id) begin
                            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                            ifid_flush = 1'b1;
                        end else begin
                            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                        end
                    end
                end
                DWAIT: begin
                    if (dhit) begin
                        adv     = 1'b1;
                        state_d = RUN;
                    end
                end
                HALT: ;
                default: state_d = RUN;
            endcase
            // Data advance: retire MEM, bubble into EX, hold ID and PC.
            if (adv) begin
                {idex_en, exmem_en, memwb_en} = 3'b111;
                idex_flush = 1'b1;
            end
            if (halt_wb) state_d = HALT;
        end
    end

    // State, sticky halt flag and saturating performance counters.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
            cycle_q  <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == HALT);
            if (state_q != HALT) begin
                if (cycle_q != '1)
                    cycle_q <= cycle_q + CNT_W'(1);
                if (!pc_en && stall_q != '1)
                    stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign halted      = halted_q;
    assign cycle_count = cycle_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: the driver applies stimulus just
// after each rising edge and queues the expected strobes and counters from
// a behavioural model; the monitor checks on the falling edge.
module tb_pipeline_sequencer;

    localparam int CNT_W = 4;
    localparam int REG_W = 5;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             ihit, dhit, dmemREN_mem, dmemWEN_mem, ex_MemRead;
    logic [REG_W-1:0] ex_wsel, id_rs, id_rt;
    logic             branch_mem, jump_id, halt_wb;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, exmem_flush, imemREN, halted;
    logic [CNT_W-1:0] cycle_count, stall_count;

    pipeline_sequencer #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .dmemREN_mem(dmemREN_mem), .dmemWEN_mem(dmemWEN_mem),
        .ex_MemRead(ex_MemRead), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
        .branch_mem(branch_mem), .jump_id(jump_id), .halt_wb(halt_wb),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .imemREN(imemREN), .halted(halted),
        .cycle_count(cycle_count), .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [8:0] strb;
        logic       hlt;
        int         cyc;
        int         stl;
    } exp_t;

    typedef enum {A_IDLE, A_DATA, A_BR, A_LUH, A_JMP, A_GO} act_t;
    typedef enum {M_RUN, M_WAIT, M_HALT} mode_t;

    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    done  = 0;
    mode_t m_mode = M_RUN;
    int    m_cyc = 0, m_stl = 0;
    bit    m_hlt = 0;

    // {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, exmem_fl}
    function automatic logic [7:0] act_vec(act_t a);
        case (a)
            A_DATA:  return 8'b00111_010;
            A_BR:    return 8'b11111_111;
            A_LUH:   return 8'b00111_010;
            A_JMP:   return 8'b11111_100;
            A_GO:    return 8'b11111_000;
            default: return 8'b00000_000;
        endcase
    endfunction

    // Reference model: expected response for the inputs now applied.
    task automatic issue();
        exp_t e;
        act_t a;
        logic dq, lu;
        logic [7:0] v;
        dq = dmemREN_mem | dmemWEN_mem;
        lu = ex_MemRead && ex_wsel != 0 && (ex_wsel == id_rs || ex_wsel == id_rt);
        if (!nRST || m_mode == M_HALT)      a = A_IDLE;
        else if (m_mode == M_WAIT || dq)    a = dhit ? A_DATA : A_IDLE;
        else if (!ihit)                     a = A_IDLE;
        else if (branch_mem)                a = A_BR;
        else if (lu)                        a = A_LUH;
        else if (jump_id)                   a = A_JMP;
        else                                a = A_GO;
        v = act_vec(a);
        e.strb = {v, nRST && m_mode == M_RUN && !dq};
        e.hlt  = m_hlt;
        e.cyc  = m_cyc;
        e.stl  = m_stl;
        sb.push_back(e);
        if (!nRST) begin
            m_mode = M_RUN; m_cyc = 0; m_stl = 0; m_hlt = 0;
        end else begin
            if (m_mode != M_HALT) begin
                if (m_cyc < CMAX) m_cyc++;
                if (!v[7] && m_stl < CMAX) m_stl++;
            end
            if (halt_wb)                            m_mode = M_HALT;
            else if (m_mode == M_RUN && dq && !dhit) m_mode = M_WAIT;
            else if (m_mode == M_WAIT && dhit)       m_mode = M_RUN;
            m_hlt = (m_mode == M_HALT);
        end
    endtask

    task automatic step();
        issue();
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet();
        nRST = 1; ihit = 0; dhit = 0; dmemREN_mem = 0; dmemWEN_mem = 0;
        ex_MemRead = 0; ex_wsel = 0; id_rs = 0; id_rt = 0;
        branch_mem = 0; jump_id = 0; halt_wb = 0;
    endtask

    task automatic randomize_inputs();
        nRST        = ($urandom_range(0, 99) != 0);
        ihit        = ($urandom_range(0, 9) < 7);
        dhit        = ($urandom_range(0, 9) < 4);
        dmemREN_mem = ($urandom_range(0, 9) < 2);
        dmemWEN_mem = ($urandom_range(0, 9) < 1);
        ex_MemRead  = ($urandom_range(0, 9) < 3);
        ex_wsel     = REG_W'($urandom_range(0, 3));
        id_rs       = REG_W'($urandom_range(0, 3));
        id_rt       = REG_W'($urandom_range(0, 3));
        branch_mem  = ($urandom_range(0, 9) < 1);
        jump_id     = ($urandom_range(0, 9) < 1);
        halt_wb     = ($urandom_range(0, 149) == 0);
    endtask

    task automatic check1(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Driver: directed scenarios, then randomized traffic.
    initial begin : driver
        quiet();
        nRST = 0;
        @(posedge CLK); #1;
        step(); step();
        quiet(); ihit = 1;
        repeat (12) step();
        // data read, dhit 3 cycles late
        quiet(); ihit = 1; dmemREN_mem = 1;
        repeat (3) step();
        dhit = 1; step();
        quiet(); ihit = 1; step(); step();
        // load-use, then same with $zero destination
        ex_MemRead = 1; ex_wsel = 5; id_rt = 5; step();
        ex_wsel = 0; id_rt = 0; step();
        // branch beats load-use
        ex_MemRead = 1; ex_wsel = 3; id_rs = 3; branch_mem = 1; step();
        quiet(); ihit = 1; jump_id = 1; step();
        // write with dhit and ihit together
        quiet(); ihit = 1; dmemWEN_mem = 1; dhit = 1; step();
        // long stall to saturate the counters
        quiet(); repeat (20) step();
        // halt together with dhit, then frozen
        quiet(); ihit = 1; dmemREN_mem = 1; dhit = 1; halt_wb = 1; step();
        quiet(); ihit = 1; repeat (4) step();
        nRST = 0; step();
        quiet(); ihit = 1; step(); step();
        // reset in the middle of DWAIT
        dmemREN_mem = 1; step(); step();
        nRST = 0; step();
        quiet(); ihit = 1; repeat (3) step();
        repeat (2000) begin
            randomize_inputs();
            step();
        end
        done = 1;
    end

    // Monitor: compare every presented cycle against the queued response.
    initial begin : monitor
        exp_t e;
        int   idle = 0;
        forever begin
            @(negedge CLK);
            if (sb.size() != 0) begin
                idle = 0;
                e = sb.pop_front();
                check1("strobes", int'({pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                       ifid_flush, idex_flush, exmem_flush, imemREN}), int'(e.strb));
                check1("halted", int'(halted), int'(e.hlt));
                check1("cycle_count", int'(cycle_count), e.cyc);
                check1("stall_count", int'(stall_count), e.stl);
            end else if (done) begin
                break;
            end else begin
                idle++;
                if (idle > 100) begin
                    n_cmp++; n_err++;
                    $display("FAIL monitor_timeout: no response got %0d idle cycles expected 0", idle);
                    break;
                end
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
